// File: rtl/sdram_arbiter_if.sv
// rtl/sdram_arbiter_if.sv - requester, sdram and grant signals shared by the sdram arbiter
interface sdram_arbiter_if #(
  parameter int AW = 25
);
  logic          dl_req;
  logic [AW-1:0] dl_addr;
  logic [7:0]    dl_din;
  logic          dl_ack;
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_ack;
  logic [7:0]    vid_dout;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_din;
  logic          cpu_ack;
  logic [7:0]    cpu_dout;
  logic [AW-1:0] sd_addr;
  logic [7:0]    sd_din;
  logic          sd_we;
  logic          sd_oe;
  logic [7:0]    sd_dout;
  logic [1:0]    grant;

  modport slave (
    input  dl_req, dl_addr, dl_din, vid_req, vid_addr,
    input  cpu_req, cpu_we, cpu_addr, cpu_din, sd_dout,
    output dl_ack, vid_ack, vid_dout, cpu_ack, cpu_dout,
    output sd_addr, sd_din, sd_we, sd_oe, grant
  );

  modport master (
    output dl_req, dl_addr, dl_din, vid_req, vid_addr,
    output cpu_req, cpu_we, cpu_addr, cpu_din, sd_dout,
    input  dl_ack, vid_ack, vid_dout, cpu_ack, cpu_dout,
    input  sd_addr, sd_din, sd_we, sd_oe, grant
  );
endinterface

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - shares the 8-bit sdram port between download, video and cpu
// Each access is a fixed slot: IDLE (arbitrate) -> ACCESS (strobe) -> DONE (ack).
module sdram_arbiter #(
  parameter int AW            = 25,
  parameter int ACCESS_CYCLES = 4,
  parameter int CPU_MAX_WAIT  = 2
) (
  input  logic           i_f14m,
  input  logic           i_reset,
  sdram_arbiter_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  localparam logic [1:0] G_NONE   = 2'd0;
  localparam logic [1:0] G_DL     = 2'd1;
  localparam logic [1:0] G_VID    = 2'd2;
  localparam logic [1:0] G_CPU    = 2'd3;
  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);
  localparam logic [2:0] MAX_WAIT = 3'(CPU_MAX_WAIT);

  state_t        r_state;
  state_t        w_next_state;
  logic [1:0]    w_pick;
  logic [3:0]    r_cnt;
  logic [1:0]    r_owner;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [7:0]    r_din;
  logic [7:0]    r_vid_dout;
  logic [7:0]    r_cpu_dout;
  logic [2:0]    r_starve;

  always_ff @(posedge i_f14m) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_owner    <= G_NONE;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_din      <= 8'd0;
      r_vid_dout <= 8'd0;
      r_cpu_dout <= 8'd0;
      r_starve   <= 3'd0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: begin
          r_owner <= w_pick;
          r_cnt   <= CNT_LOAD;
          if (w_pick == G_DL) begin
            r_addr <= bus.dl_addr;
            r_din  <= bus.dl_din;
            r_we   <= 1'b1;
          end else if (w_pick == G_VID) begin
            r_addr <= bus.vid_addr;
            r_we   <= 1'b0;
          end else if (w_pick == G_CPU) begin
            r_addr <= bus.cpu_addr;
            r_din  <= bus.cpu_din;
            r_we   <= bus.cpu_we;
          end
          // a download grant never touches the cpu starvation count
          if (w_pick == G_CPU || (w_pick != G_DL && !bus.cpu_req)) begin
            r_starve <= 3'd0;
          end else if (w_pick == G_VID && r_starve != 3'd7) begin
            r_starve <= r_starve + 3'd1;
          end
        end
        S_ACCESS: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd0 && !r_we) begin
            if (r_owner == G_VID) begin
              r_vid_dout <= bus.sd_dout;
            end else if (r_owner == G_CPU) begin
              r_cpu_dout <= bus.sd_dout;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_pick = G_NONE;
    if (bus.dl_req) begin
      w_pick = G_DL;
    end else if (bus.cpu_req && (!bus.vid_req || r_starve >= MAX_WAIT)) begin
      w_pick = G_CPU;
    end else if (bus.vid_req) begin
      w_pick = G_VID;
    end

    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (w_pick != G_NONE) w_next_state = S_ACCESS;
      S_ACCESS: if (r_cnt == 4'd0) w_next_state = S_DONE;
      S_DONE:   w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    bus.sd_we   = 1'b0;
    bus.sd_oe   = 1'b0;
    bus.grant   = G_NONE;
    bus.dl_ack  = 1'b0;
    bus.vid_ack = 1'b0;
    bus.cpu_ack = 1'b0;
    case (r_state)
      S_ACCESS: begin
        bus.sd_we = r_we;
        bus.sd_oe = !r_we;
        bus.grant = r_owner;
      end
      S_DONE: begin
        bus.grant   = r_owner;
        bus.dl_ack  = (r_owner == G_DL);
        bus.vid_ack = (r_owner == G_VID);
        bus.cpu_ack = (r_owner == G_CPU);
      end
      default: ;
    endcase
  end

  assign bus.sd_addr  = r_addr;
  assign bus.sd_din   = r_din;
  assign bus.vid_dout = r_vid_dout;
  assign bus.cpu_dout = r_cpu_dout;
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - randomized requesters and sdram memory against a slot-level model
// Agents: 0 = download, 1 = video, 2 = cpu; grant code is agent index + 1.
module tb_sdram_arbiter;
  localparam int AW   = 25;
  localparam int AC   = 4;
  localparam int MAXW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sdram_arbiter_if #(.AW(AW)) bus ();

  sdram_arbiter #(.AW(AW), .ACCESS_CYCLES(AC), .CPU_MAX_WAIT(MAXW)) dut (
    .i_f14m  (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  logic          a_req  [3];
  logic [AW-1:0] a_addr [3];
  logic [7:0]    a_din  [3];
  logic          a_we   [3];
  int            p_req  [3];
  int            p_b2b  [3];
  int            brem   [3];
  int            issued [3];
  int            acked  [3];
  logic [7:0]    mem [logic [AW-1:0]];

  int            m_cnt;
  int            m_own;
  int            m_starve;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [AW-1:0] m_last_addr;
  logic [7:0]    m_din;
  logic [7:0]    m_last_din;
  logic [7:0]    m_vdout;
  logic [7:0]    m_cdout;

  int         cyc;
  int         glog[$];
  int         ack_cyc[$];
  logic [1:0] prev_grant;
  int         exp4[6] = '{2, 2, 3, 2, 2, 3};
  int         exp5[7] = '{2, 1, 1, 1, 1, 2, 3};

  function automatic logic [7:0] rd(input logic [AW-1:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ a[15:8];
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom);
    return AW'(32'h1F800 + $urandom_range(0, 15));
  endfunction

  task automatic drive();
    bus.dl_req   = a_req[0];
    bus.dl_addr  = a_addr[0];
    bus.dl_din   = a_din[0];
    bus.vid_req  = a_req[1];
    bus.vid_addr = a_addr[1];
    bus.cpu_req  = a_req[2];
    bus.cpu_addr = a_addr[2];
    bus.cpu_din  = a_din[2];
    bus.cpu_we   = a_we[2];
  endtask

  task automatic raise(input int i, input logic we, input logic [AW-1:0] addr, input logic [7:0] din);
    a_req[i]  = 1'b1;
    a_we[i]   = (i == 0) ? 1'b1 : ((i == 1) ? 1'b0 : we);
    a_addr[i] = addr;
    a_din[i]  = din;
    issued[i]++;
    drive();
  endtask

  // One access = one winner chosen from the pending requests, then AC strobe cycles and one ack cycle.
  task automatic model_edge();
    int w;
    if (rst) begin
      m_cnt = 0; m_own = 0; m_starve = 0; m_vdout = 8'd0; m_cdout = 8'd0;
      m_last_addr = '0; m_last_din = 8'd0;
      return;
    end
    if (m_cnt == 0) begin
      w = 0;
      if (a_req[0]) w = 1;
      else if (a_req[1] && a_req[2]) w = (m_starve >= MAXW) ? 3 : 2;
      else if (a_req[1]) w = 2;
      else if (a_req[2]) w = 3;
      if (w == 3 || (w != 1 && !a_req[2])) m_starve = 0;
      else if (w == 2) m_starve = (m_starve < 7) ? m_starve + 1 : 7;
      if (w != 0) begin
        m_own = w; m_we = a_we[w-1]; m_addr = a_addr[w-1]; m_din = a_din[w-1];
        m_last_addr = m_addr;
        if (w != 2) m_last_din = m_din;
        m_cnt = 1;
      end
    end else if (m_cnt <= AC) begin
      if (m_cnt == AC && !m_we) begin
        if (m_own == 2) m_vdout = rd(m_addr);
        else m_cdout = rd(m_addr);
      end
      m_cnt++;
    end else begin
      if (m_we) mem[m_addr] = m_din;
      m_cnt = 0;
    end
  endtask

  task automatic step();
    logic strobe;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    strobe = (m_cnt >= 1 && m_cnt <= AC);
    check("grant", bus.grant, (m_cnt == 0) ? 0 : m_own);
    check("sd_we", bus.sd_we, strobe && m_we);
    check("sd_oe", bus.sd_oe, strobe && !m_we);
    check("dl_ack", bus.dl_ack, m_cnt == AC + 1 && m_own == 1);
    check("vid_ack", bus.vid_ack, m_cnt == AC + 1 && m_own == 2);
    check("cpu_ack", bus.cpu_ack, m_cnt == AC + 1 && m_own == 3);
    check("sd_addr", bus.sd_addr, m_last_addr);
    check("sd_din", bus.sd_din, m_last_din);
    check("vid_dout", bus.vid_dout, m_vdout);
    check("cpu_dout", bus.cpu_dout, m_cdout);
    if (bus.grant != 2'd0 && prev_grant == 2'd0) glog.push_back(int'(bus.grant));
    prev_grant = bus.grant;
    if (bus.dl_ack) acked[0]++;
    if (bus.vid_ack) acked[1]++;
    if (bus.cpu_ack) begin
      acked[2]++;
      ack_cyc.push_back(cyc);
    end
    for (int i = 0; i < 3; i++) begin
      if (m_cnt == AC + 1 && m_own == i + 1) begin
        a_req[i] = 1'b0;
        if (brem[i] > 0) begin
          brem[i]--;
          raise(i, 1'($urandom), rand_addr(), 8'($urandom));
        end else if ($urandom_range(0, 99) < p_b2b[i]) begin
          raise(i, 1'($urandom), rand_addr(), 8'($urandom));
        end
      end else if (strobe && m_own == i + 1) begin
        if ($urandom_range(0, 1) == 1) begin
          a_addr[i] = rand_addr();
          a_din[i]  = 8'($urandom);
          if (i == 2) a_we[i] = 1'($urandom);
        end
      end else if (!a_req[i] && !rst && $urandom_range(0, 99) < p_req[i]) begin
        raise(i, 1'($urandom), rand_addr(), 8'($urandom));
      end
    end
    bus.sd_dout = (m_cnt == AC && !m_we) ? rd(m_addr) : 8'($urandom);
    drive();
  endtask

  task automatic reset_agents();
    for (int i = 0; i < 3; i++) begin
      if (a_req[i]) issued[i]--;
      a_req[i] = 1'b0;
      brem[i]  = 0;
    end
    drive();
  endtask

  task automatic pulse_reset(input int n);
    rst = 1'b1;
    reset_agents();
    repeat (n) step();
    rst = 1'b0;
  endtask

  task automatic wait_ack(input int i, input int budget, input string tag);
    int n;
    n = acked[i];
    for (int k = 0; k < budget && acked[i] == n; k++) step();
    check(tag, acked[i] - n, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) begin
      p_req[i] = 0; p_b2b[i] = 0; brem[i] = 0;
    end
    for (int k = 0; k < 200 && (a_req[0] || a_req[1] || a_req[2] || m_cnt != 0); k++) step();
    check("drained", a_req[0] | a_req[1] | a_req[2], 0);
    repeat (2) step();
  endtask

  task automatic wait_grants(input int n, input int budget);
    for (int k = 0; k < budget && glog.size() < n; k++) step();
    check("grant_count", glog.size() >= n, 1);
  endtask

  initial begin
    int c0;
    int v0;
    rst = 1'b1;
    cyc = 0;
    prev_grant = 2'd0;
    for (int i = 0; i < 3; i++) begin
      a_req[i] = 1'b0; a_addr[i] = '0; a_din[i] = 8'd0; a_we[i] = 1'b0;
      p_req[i] = 0; p_b2b[i] = 0; brem[i] = 0; issued[i] = 0; acked[i] = 0;
    end
    m_cnt = 0; m_own = 0; m_starve = 0; m_we = 1'b0; m_addr = '0; m_din = 8'd0;
    m_last_addr = '0; m_last_din = 8'd0; m_vdout = 8'd0; m_cdout = 8'd0;
    bus.sd_dout = 8'd0;
    drive();
    repeat (3) step();
    rst = 1'b0;
    repeat (2) step();

    mem[AW'(32'h00123)] = 8'hA5;
    c0 = cyc;
    raise(2, 1'b0, AW'(32'h00123), 8'h00);
    wait_ack(2, 20, "t2_ack");
    check("t2_latency", cyc - c0, AC + 1);
    check("t2_cpu_dout", bus.cpu_dout, 8'hA5);
    repeat (2) step();

    raise(2, 1'b1, AW'(32'h1F800), 8'h41);
    wait_ack(2, 20, "t3_ack0");
    raise(2, 1'b1, AW'(32'h1F801), 8'h42);
    wait_ack(2, 20, "t3_ack1");
    check("t3_spacing", ack_cyc[ack_cyc.size()-1] - ack_cyc[ack_cyc.size()-2], AC + 2);
    drain();

    glog.delete();
    p_req[1] = 100; p_req[2] = 100; p_b2b[1] = 100; p_b2b[2] = 100;
    wait_grants(6, 100);
    for (int k = 0; k < 6; k++) check($sformatf("t4_grant%0d", k), (k < glog.size()) ? glog[k] : 0, exp4[k]);
    drain();

    glog.delete();
    p_req[1] = 100; p_req[2] = 100; p_b2b[1] = 100; p_b2b[2] = 100;
    wait_grants(1, 20);
    c0 = acked[0];
    brem[0] = 3;
    raise(0, 1'b1, rand_addr(), 8'($urandom));
    wait_grants(7, 150);
    for (int k = 0; k < 7; k++) check($sformatf("t5_grant%0d", k), (k < glog.size()) ? glog[k] : 0, exp5[k]);
    drain();
    check("t6_dl_acks", acked[0] - c0, 4);

    raise(1, 1'b0, rand_addr(), 8'd0);
    repeat (2) step();
    v0 = acked[1];
    pulse_reset(3);
    repeat (5) step();
    check("t1_no_ack", acked[1] - v0, 0);
    raise(1, 1'b0, rand_addr(), 8'd0);
    wait_ack(1, 20, "t1_after_reset");
    repeat (2) step();

    for (int blk = 0; blk < 8; blk++) begin
      for (int i = 0; i < 3; i++) begin
        p_req[i] = $urandom_range(0, 60);
        p_b2b[i] = $urandom_range(0, 60);
      end
      for (int k = 0; k < 200; k++) begin
        if ($urandom_range(0, 299) == 0) pulse_reset($urandom_range(1, 3));
        else step();
      end
    end
    drain();
    for (int i = 0; i < 3; i++) check($sformatf("acks_agent%0d", i), acked[i], issued[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
